adder_3bit_arbiter: RTL and testbench

Round-robin arbiter and result buffer sharing one mod-8 residue adder among `N_REQ` requesters in the RNS datapath. Each requester presents a residue pair with a valid/ready handshake. The block grants one requester per cycle and computes (a + b) mod 8 through a single adder instance. It returns the sum with the winning requester's index through a one-entry registered output stage with its own valid/ready handshake.

---
 rtl/rns_pkg.sv | 18 +
 rtl/adder_3bit.sv | 20 ++
 rtl/adder_3bit_arbiter.sv | 126 ++++++++++++
 tb/tb_adder_3bit_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rns_pkg.sv
// Shared RNS residue types and constants for the mod-8 datapath.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package rns_pkg;

  // Residues are 3-bit values; arithmetic wraps modulo MOD8 = 2**RES_W.
  localparam int RES_W = 3;
  localparam int MOD8  = 8;

  typedef logic [RES_W-1:0] residue_t;

  // Occupancy of the one-entry result register.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/adder_3bit.sv
// Mod-8 residue adder: sum = (a + b) mod 8, carry out dropped.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   a, b  in   residue operands
//   sum   out  (a + b) mod 8
module adder_3bit
  import rns_pkg::*;
(
  input  residue_t a,
  input  residue_t b,
  output residue_t sum
);

  // Result is sized to the residue width, so the carry is discarded and
  // the wrap modulo 8 happens for free.
  assign sum = a + b;

endmodule

// File: rtl/adder_3bit_arbiter.sv
// Round-robin arbiter sharing one mod-8 adder among N_REQ requesters.
// Latency: 1 cycle from request-side transfer to res_valid.
// Backpressure: all req_ready low while the result register is full and res_ready is low.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   per-requester handshake; req_ready is one-hot grant
//   req_a, req_b      packed operands, requester i at bits [3i+2:3i]
//   res_valid/ready   output handshake for the registered result
//   res_data, res_id  sum and index of the requester that produced it
module adder_3bit_arbiter
  import rns_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [RES_W*N_REQ-1:0] req_a,
  input  logic [RES_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [RES_W-1:0]       res_data,
  output logic [ID_W-1:0]        res_id
);

  out_state_t      state_q;
  out_state_t      state_d;
  logic [ID_W-1:0] ptr_q;
  residue_t        res_data_q;
  logic [ID_W-1:0] res_id_q;

  logic            found;
  logic [ID_W-1:0] win;
  int              idx;
  logic            can_accept;
  logic            xfer;
  residue_t        op_a;
  residue_t        op_b;
  residue_t        sum;

  // Round-robin scan starting at ptr_q and wrapping at N_REQ-1; the first
  // asserted req_valid wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  // The register can take new data when empty or when it is being drained
  // in the same cycle.
  assign can_accept = !res_valid || res_ready;
  assign xfer       = !rst && found && can_accept;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[win] = 1'b1;
  end

  // Operand mux for the granted requester feeding the single shared adder.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == ID_W'(i)) begin
        op_a = req_a[i*RES_W +: RES_W];
        op_b = req_b[i*RES_W +: RES_W];
      end
    end
  end

  adder_3bit u_adder (
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

  // Output register occupancy: state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= OUT_EMPTY;
    else     state_q <= state_d;
  end

  // Output register occupancy: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: if (xfer) state_d = OUT_FULL;
      OUT_FULL:  if (!xfer && res_ready) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
  end

  // Output register occupancy: outputs.
  always_comb begin
    res_valid = (state_q == OUT_FULL);
  end

  // Result payload and priority pointer only move on a request-side transfer,
  // so a stalled result stays stable and an idle cycle leaves ptr alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      res_data_q <= '0;
      res_id_q   <= '0;
    end else if (xfer) begin
      res_data_q <= sum;
      res_id_q   <= win;
      ptr_q      <= (win == ID_W'(N_REQ-1)) ? '0 : win + 1'b1;
    end
  end

  assign res_data = res_data_q;
  assign res_id   = res_id_q;

endmodule

// File: tb/tb_adder_3bit_arbiter.sv
// Self-checking bench for adder_3bit_arbiter against a queue-free scoreboard model.
// Latency: model advances one step per clock edge.
// Backpressure: res_ready driven by directed tests and random draws.
module tb_adder_3bit_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [3*N-1:0] req_a;
  logic [3*N-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic           res_ready;
  logic [2:0]     res_data;
  logic [1:0]     res_id;

  always #5 clk = ~clk;

  adder_3bit_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: pointer, and the one result slot.
  int m_ptr  = 0;
  bit m_vld  = 0;
  int m_data = 0;
  int m_id   = 0;

  function automatic int winner();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int w;
    logic [N-1:0] r;
    w = winner();
    r = '0;
    if (!rst && w >= 0 && (!m_vld || res_ready)) r[w] = 1'b1;
    return r;
  endfunction

  // Payload only matters while the slot holds a result.
  function automatic logic [9:0] exp_bus();
    logic [2:0] d;
    logic [1:0] id;
    d  = m_vld ? 3'(m_data) : 3'd0;
    id = m_vld ? 2'(m_id)   : 2'd0;
    return {exp_ready(), m_vld, d, id};
  endfunction

  function automatic logic [9:0] obs_bus();
    return {req_ready, res_valid, res_valid ? {res_data, res_id} : 5'd0};
  endfunction

  task automatic set_in(input logic [N-1:0] v, input logic [3*N-1:0] a,
                        input logic [3*N-1:0] b, input logic rdy);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    res_ready = rdy;
    #1;
  endtask

  // Advance one clock edge and step the model with the inputs seen at it.
  task automatic tick();
    int w;
    bit acc;
    int a;
    int b;
    a   = 0;
    b   = 0;
    w   = winner();
    acc = !m_vld || res_ready;
    if (w >= 0) begin
      a = int'(req_a[3*w +: 3]);
      b = int'(req_b[3*w +: 3]);
    end
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_vld = 0; m_data = 0; m_id = 0;
    end else if (w >= 0 && acc) begin
      m_data = (a + b) % 8;
      m_id   = w;
      m_vld  = 1;
      m_ptr  = (w + 1) % N;
    end else if (m_vld && res_ready) begin
      m_vld = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(4'b1111, 12'($urandom), 12'($urandom), 1'b1);
    n_chk++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready got %b exp 0000", req_ready);
    end
    tick(); tick();
    n_chk++;
    if ({req_ready, res_valid, res_data, res_id} !== 10'd0) begin
      n_fail++; $display("FAIL reset_state got %b exp 0", {req_ready, res_valid, res_data, res_id});
    end
    rst = 1'b0;
    // Fill the slot with 5 from requester 2 and hold it.
    set_in(4'b0100, 12'(2 << 6), 12'(3 << 6), 1'b0);
    tick();
    set_in(4'b1111, 12'($urandom), 12'($urandom), 1'b0);
    n_chk++;
    if ({res_valid, res_data, res_id} !== {1'b1, 3'd5, 2'd2} || req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_full got v%b d%0d id%0d rdy%b exp v1 d5 id2 rdy0000",
                         res_valid, res_data, res_id, req_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_chk++;
    if ({res_valid, res_data, res_id} !== 6'd0 || req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL reset_midop got v%b d%0d id%0d rdy%b exp v0 d0 id0 rdy0001",
                         res_valid, res_data, res_id, req_ready);
    end
    tick();
  endtask

  task automatic test_single();
    set_in(4'b0000, 12'd0, 12'd0, 1'b1);
    tick();
    set_in(4'b0010, 12'(3 << 3), 12'(6 << 3), 1'b1);
    n_chk++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL single_ready got %b exp 0010", req_ready);
    end
    tick();
    n_chk++;
    if ({res_valid, res_data, res_id} !== {1'b1, 3'd1, 2'd1}) begin
      n_fail++; $display("FAIL single_result got v%b d%0d id%0d exp v1 d1 id1",
                         res_valid, res_data, res_id);
    end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    set_in(4'b0000, 12'd0, 12'd0, 1'b1);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      set_in(4'b1111, 12'($urandom), 12'($urandom), 1'b1);
      n_chk++;
      if (req_ready !== 4'(1 << order[c]) || obs_bus() !== exp_bus()) begin
        n_fail++; $display("FAIL rr_cycle%0d got %b exp rdy %b bus %b",
                           c, obs_bus(), 4'(1 << order[c]), exp_bus());
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] d0;
    logic [1:0] i0;
    d0 = res_data;
    i0 = res_id;
    for (int c = 0; c < 3; c++) begin
      set_in(4'b1111, 12'($urandom), 12'($urandom), 1'b0);
      n_chk++;
      if (req_ready !== 4'b0000 || !res_valid || res_data !== d0 || res_id !== i0) begin
        n_fail++; $display("FAIL bp_stall%0d got rdy%b v%b d%0d id%0d exp rdy0000 v1 d%0d id%0d",
                           c, req_ready, res_valid, res_data, res_id, d0, i0);
      end
      tick();
    end
    set_in(4'b1111, 12'($urandom), 12'($urandom), 1'b1);
    n_chk++;
    if (req_ready !== 4'b0010 || obs_bus() !== exp_bus()) begin
      n_fail++; $display("FAIL bp_release got %b exp rdy 0010 bus %b", obs_bus(), exp_bus());
    end
    tick();
  endtask

  task automatic test_wrap();
    int pa[3] = '{7, 4, 0};
    int pb[3] = '{7, 4, 0};
    int ps[3] = '{6, 0, 0};
    for (int c = 0; c < 3; c++) begin
      set_in(4'b1000, 12'(pa[c] << 9), 12'(pb[c] << 9), 1'b1);
      tick();
      n_chk++;
      if (res_data !== 3'(ps[c]) || res_id !== 2'd3 || !res_valid) begin
        n_fail++; $display("FAIL wrap_%0d+%0d got d%0d id%0d exp d%0d id3",
                           pa[c], pb[c], res_data, res_id, ps[c]);
      end
    end
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        set_in(4'b1000, 12'(a << 9), 12'(b << 9), 1'b1);
        tick();
        n_chk++;
        if (res_data !== 3'((a + b) % 8) || obs_bus() !== exp_bus()) begin
          n_fail++; $display("FAIL sweep_%0d+%0d got d%0d exp d%0d", a, b, res_data, (a + b) % 8);
        end
      end
    end
  endtask

  task automatic test_idle();
    set_in(4'b0100, 12'($urandom), 12'($urandom), 1'b1);
    tick();
    for (int c = 0; c < 5; c++) begin
      set_in(4'b0000, 12'($urandom), 12'($urandom), 1'b1);
      n_chk++;
      if (req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL idle_%0d got rdy %b exp 0000", c, req_ready);
      end
      tick();
    end
    set_in(4'b1001, 12'($urandom), 12'($urandom), 1'b1);
    n_chk++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL idle_grant got rdy %b exp 1000", req_ready);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) < 2);
      set_in(4'($urandom), 12'($urandom), 12'($urandom), ($urandom_range(0, 9) < 7));
      n_chk++;
      if (obs_bus() !== exp_bus()) begin
        n_fail++; $display("FAIL random_%0d got %b exp %b", c, obs_bus(), exp_bus());
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_idle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
